// File: rtl/uart_tx_oversampled.sv
// rtl/uart_tx_oversampled.sv - oversampled UART transmitter: start bit, LSB-first data, tick-counted stop period
module uart_tx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    // The tick counter is shared between bit cells and the stop period,
    // so it is sized for whichever of the two is longer.
    localparam int S_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] OS_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(STOP_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BITS - 1);
    localparam logic [S_W-1:0] S_ONE     = S_W'(1);
    localparam logic [N_W-1:0] N_ONE     = N_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [S_W-1:0]       s_cnt;
    logic [S_W-1:0]       s_cnt_next;
    logic [N_W-1:0]       n_cnt;
    logic [N_W-1:0]       n_cnt_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 done_next;

    // State, counters, shift register and all outputs update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            s_cnt        <= s_cnt_next;
            n_cnt        <= n_cnt_next;
            shift        <= shift_next;
            tx           <= tx_next;
            tx_busy      <= busy_next;
            tx_done_tick <= done_next;
        end
    end

    // Frame sequencing; outputs are derived from the next state so that
    // tx and tx_busy change on the edge that enters a state, with no input-to-tx path.
    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_cnt_next = n_cnt;
        shift_next = shift;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                // A coincident s_tick is deliberately not counted here.
                if (tx_start) begin
                    shift_next = tx_data;
                    s_cnt_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_cnt_next = '0;
                        n_cnt_next = '0;
                        state_next = DATA;
                    end else begin
                        s_cnt_next = s_cnt + S_ONE;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_cnt_next = '0;
                        shift_next = shift >> 1;
                        if (n_cnt == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt + N_ONE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + S_ONE;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        s_cnt_next = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt + S_ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule
